// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART-FIFO side signals of uart_tx_arbiter.
// master: the arbiter itself; slave: requesters plus FIFO (the environment).
interface uart_tx_arbiter_if;
  logic [2:0]  req;
  logic [23:0] dat_in;
  logic [2:0]  last;
  logic [2:0]  ack;
  logic [2:0]  grant;
  logic [7:0]  fifo_dat;
  logic        fifo_dat_en;
  logic        fifo_afull;
  logic        fifo_full;
  logic        busy;

  modport master (
    input  req, dat_in, last, fifo_afull, fifo_full,
    output ack, grant, fifo_dat, fifo_dat_en, busy
  );

  modport slave (
    output req, dat_in, last, fifo_afull, fifo_full,
    input  ack, grant, fifo_dat, fifo_dat_en, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter merging three byte-stream requesters into one UART TX FIFO.
// Optional per-grant header byte (0xA0 | id) enabled by defining UART_TX_ARB_HEADER_EN.
module uart_tx_arbiter #(
  parameter int unsigned MAX_PKT = 64
) (
  input logic              clk_100MHz,
  input logic              reset,
  uart_tx_arbiter_if.master bus
);
  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned CNT_W   = 7;
  localparam int unsigned ID_W    = 2;
  localparam logic [BYTE_W-1:0] HDR_BASE = 8'hA0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    RELEASE = 2'd2
`ifdef UART_TX_ARB_HEADER_EN
    , HDR   = 2'd3
`endif
  } state_t;

  state_t              state;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     gid;
  logic [ID_W-1:0]     last_id;
  logic [ID_W-1:0]     pick_id;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_inc;
  logic [BYTE_W-1:0]   fifo_dat;
  logic                fifo_dat_en;
  logic                stall;
  logic                sel_req;
  logic                sel_last;
  logic [BYTE_W-1:0]   sel_byte;
  logic                pkt_done;
  logic [NUM_REQ-1:0]  ack_c;

  assign stall    = bus.fifo_afull | bus.fifo_full;
  assign cnt_inc  = cnt + CNT_W'(1);
  assign pkt_done = sel_last || (cnt_inc == CNT_W'(MAX_PKT));
  assign ack_c    = (state == SEND && !stall) ? (grant & bus.req) : '0;

  assign bus.ack         = ack_c;
  assign bus.grant       = grant;
  assign bus.fifo_dat    = fifo_dat;
  assign bus.fifo_dat_en = fifo_dat_en;
  assign bus.busy        = (state != IDLE);

  // Mux the granted requester's lane
  always_comb begin
    sel_req  = bus.req[0];
    sel_last = bus.last[0];
    sel_byte = bus.dat_in[7:0];
    case (gid)
      2'd1: begin
        sel_req  = bus.req[1];
        sel_last = bus.last[1];
        sel_byte = bus.dat_in[15:8];
      end
      2'd2: begin
        sel_req  = bus.req[2];
        sel_last = bus.last[2];
        sel_byte = bus.dat_in[23:16];
      end
      default: ;
    endcase
  end

  // Round-robin search starting just after the previously served requester
  always_comb begin
    pick_id = 2'd0;
    case (last_id)
      2'd0: begin
        if (bus.req[1])      pick_id = 2'd1;
        else if (bus.req[2]) pick_id = 2'd2;
        else                 pick_id = 2'd0;
      end
      2'd1: begin
        if (bus.req[2])      pick_id = 2'd2;
        else if (bus.req[0]) pick_id = 2'd0;
        else                 pick_id = 2'd1;
      end
      default: begin
        if (bus.req[0])      pick_id = 2'd0;
        else if (bus.req[1]) pick_id = 2'd1;
        else                 pick_id = 2'd2;
      end
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      gid         <= '0;
      last_id     <= 2'd2;
      cnt         <= '0;
      fifo_dat    <= '0;
      fifo_dat_en <= 1'b0;
    end else begin
      fifo_dat_en <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            gid   <= pick_id;
            grant <= NUM_REQ'(1) << pick_id;
            cnt   <= '0;
`ifdef UART_TX_ARB_HEADER_EN
            state <= HDR;
`else
            state <= SEND;
`endif
          end else begin
            grant <= '0;
          end
        end
`ifdef UART_TX_ARB_HEADER_EN
        HDR: begin
          if (!stall) begin
            fifo_dat    <= HDR_BASE | BYTE_W'(gid);
            fifo_dat_en <= 1'b1;
            state       <= SEND;
          end
        end
`endif
        SEND: begin
          // A granted requester dropping req mid-packet ends its turn without a write
          if (!stall) begin
            if (sel_req) begin
              fifo_dat    <= sel_byte;
              fifo_dat_en <= 1'b1;
              cnt         <= cnt_inc;
              if (pkt_done) state <= RELEASE;
            end else begin
              state <= RELEASE;
            end
          end
        end
        RELEASE: begin
          last_id <= gid;
          grant   <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of grants, acks and FIFO writes.
module tb_uart_tx_arbiter;
  localparam int unsigned MAXP = 4;

  logic clk_100MHz = 1'b0;
  logic reset;
  always #5 clk_100MHz = ~clk_100MHz;

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(.MAX_PKT(MAXP)) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .bus        (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Per-source pending bytes: {last, byte}
  logic [8:0] srcq [3][$];
  logic [7:0] pay_log [$];
  logic [7:0] all_log [$];
  logic [2:0] grant_log [$];

  logic [2:0]  req_mask = 3'b111;
  int unsigned stall_pct = 0;
  int          afull_cnt = 0;
  int          ack_cnt = 0;
  int          n_pushed = 0;

  // Model of expected observable behaviour
  logic [2:0] exp_grant;
  logic       exp_en;
  logic [7:0] exp_dat;
  bit         exp_is_hdr;
  bit         live, rel, hdr_pend;
  int         cnt, gid, last_id;
  logic [2:0] prev_grant;

`ifdef UART_TX_ARB_HEADER_EN
  localparam bit HDR_ON = 1'b1;
`else
  localparam bit HDR_ON = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int pick(input logic [2:0] r, input int lid);
    int idx;
    for (int k = 1; k <= 3; k++) begin
      idx = (lid + k) % 3;
      if (r[idx]) return idx;
    end
    return 0;
  endfunction

  task automatic model_reset();
    exp_grant = '0; exp_en = 1'b0; exp_dat = '0; exp_is_hdr = 1'b0;
    live = 1'b0; rel = 1'b0; hdr_pend = 1'b0;
    cnt = 0; gid = 0; last_id = 2; prev_grant = '0;
    for (int i = 0; i < 3; i++) srcq[i].delete();
  endtask

  task automatic push_pkt(input int src, input int len, input bit term);
    for (int k = 0; k < len; k++) begin
      srcq[src].push_back({term && (k == len - 1), 8'($urandom)});
    end
    n_pushed += len;
  endtask

  task automatic step(input bit do_reset);
    logic [2:0]  r, l, exp_ack;
    logic [23:0] d;
    logic [8:0]  h, b;
    bit          st, nen, nhdr;
    @(negedge clk_100MHz);
    reset = do_reset;
    r = '0; l = '0; d = '0;
    for (int i = 0; i < 3; i++) begin
      if (srcq[i].size() > 0 && req_mask[i]) begin
        h = srcq[i][0];
        r[i] = 1'b1;
        l[i] = h[8];
        d[8*i +: 8] = h[7:0];
      end
    end
    bus.req = r; bus.last = l; bus.dat_in = d;
    if (afull_cnt > 0) begin
      bus.fifo_afull = 1'b1;
      afull_cnt--;
    end else begin
      bus.fifo_afull = ($urandom_range(99) < stall_pct);
    end
    bus.fifo_full = ($urandom_range(99) < stall_pct / 2);
    st = bus.fifo_afull | bus.fifo_full;
    #1;
    chk("grant", bus.grant, exp_grant);
    chk("busy", bus.busy, exp_grant != 3'b000);
    chk("fifo_dat_en", bus.fifo_dat_en, exp_en);
    if (exp_en) chk("fifo_dat", bus.fifo_dat, exp_dat);
    exp_ack = (live && !hdr_pend && !st) ? (r & 3'(1 << gid)) : 3'b000;
    chk("ack", bus.ack, exp_ack);

    if (bus.ack != 3'b000) ack_cnt++;
    if (prev_grant == 3'b000 && bus.grant != 3'b000) grant_log.push_back(bus.grant);
    prev_grant = bus.grant;
    if (bus.fifo_dat_en) begin
      all_log.push_back(bus.fifo_dat);
      if (!exp_is_hdr) pay_log.push_back(bus.fifo_dat);
    end

    nen = 1'b0; nhdr = 1'b0;
    if (do_reset) begin
      model_reset();
    end else if (rel) begin
      rel = 1'b0;
      last_id = gid;
      exp_grant = '0;
    end else if (live) begin
      if (hdr_pend) begin
        if (!st) begin
          nen = 1'b1; nhdr = 1'b1; hdr_pend = 1'b0;
          exp_dat = 8'hA0 | 8'(gid);
        end
      end else if (!st) begin
        if (r[gid]) begin
          b = srcq[gid].pop_front();
          nen = 1'b1;
          exp_dat = b[7:0];
          cnt++;
          if (b[8] || cnt == int'(MAXP)) begin live = 1'b0; rel = 1'b1; end
        end else begin
          live = 1'b0; rel = 1'b1;
        end
      end
    end else begin
      if (r != 3'b000) begin
        gid = pick(r, last_id);
        exp_grant = 3'(1 << gid);
        live = 1'b1; cnt = 0; hdr_pend = HDR_ON;
      end else begin
        exp_grant = '0;
      end
    end
    exp_en = nen;
    exp_is_hdr = nhdr;
  endtask

  task automatic drain(input int bound);
    int k = 0;
    bit tmo;
    while ((srcq[0].size() > 0 || srcq[1].size() > 0 || srcq[2].size() > 0 ||
            live || rel || exp_grant != 3'b000) && k < bound) begin
      step(1'b0);
      k++;
    end
    tmo = (k >= bound);
    chk("drain_timeout", 32'(tmo), 32'd0);
    step(1'b0);
    step(1'b0);
  endtask

  initial begin
    logic [7:0] v [$];
    bus.req = '0; bus.dat_in = '0; bus.last = '0;
    bus.fifo_afull = 1'b0; bus.fifo_full = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk_100MHz);
    model_reset();

    // Reset state
    step(1'b0);
    chk("rst_fifo_dat", bus.fifo_dat, 32'h00);

    // Single packet 0x11,0x22,0x33
    pay_log.delete();
    srcq[0].push_back(9'h011); srcq[0].push_back(9'h022); srcq[0].push_back(9'h133);
    drain(100);
    chk("p1_len", pay_log.size(), 3);
    if (pay_log.size() == 3) begin
      chk("p1_b0", pay_log[0], 32'h11);
      chk("p1_b1", pay_log[1], 32'h22);
      chk("p1_b2", pay_log[2], 32'h33);
    end

    // Rotation with all three requesting one-byte packets
    step(1'b1);
    grant_log.delete();
    push_pkt(0, 1, 1'b1); push_pkt(0, 1, 1'b1);
    push_pkt(1, 1, 1'b1); push_pkt(2, 1, 1'b1);
    drain(100);
    chk("rr_len", grant_log.size(), 4);
    if (grant_log.size() == 4) begin
      chk("rr_g0", grant_log[0], 32'b001);
      chk("rr_g1", grant_log[1], 32'b010);
      chk("rr_g2", grant_log[2], 32'b100);
      chk("rr_g3", grant_log[3], 32'b001);
    end

    // almost-full held 5 cycles mid-packet
    pay_log.delete();
    srcq[1].push_back(9'h0A1); srcq[1].push_back(9'h0A2); srcq[1].push_back(9'h1A3);
    repeat (3) step(1'b0);
    afull_cnt = 5;
    drain(100);
    chk("st_len", pay_log.size(), 3);
    if (pay_log.size() == 3) begin
      chk("st_b0", pay_log[0], 32'hA1);
      chk("st_b1", pay_log[1], 32'hA2);
      chk("st_b2", pay_log[2], 32'hA3);
    end

    // MAX_PKT cut of an unterminated stream, then truncation on req drop
    step(1'b1);
    pay_log.delete(); grant_log.delete();
    for (int k = 0; k < 6; k++) srcq[1].push_back({1'b0, 8'(8'h60 + k)});
    srcq[2].push_back(9'h1C0);
    drain(200);
    v = '{8'h60, 8'h61, 8'h62, 8'h63, 8'hC0, 8'h64, 8'h65};
    chk("mx_len", pay_log.size(), v.size());
    if (pay_log.size() == v.size())
      for (int k = 0; k < v.size(); k++) chk($sformatf("mx_b%0d", k), pay_log[k], v[k]);
    chk("mx_glen", grant_log.size(), 3);
    if (grant_log.size() == 3) begin
      chk("mx_g0", grant_log[0], 32'b010);
      chk("mx_g1", grant_log[1], 32'b100);
      chk("mx_g2", grant_log[2], 32'b010);
    end

    // Reset in the middle of a packet
    begin
      int base = ack_cnt;
      int k = 0;
      push_pkt(0, 4, 1'b1);
      while (ack_cnt == base && k < 20) begin step(1'b0); k++; end
      chk("mid_ack_seen", 32'(ack_cnt > base), 32'd1);
      step(1'b1);
      step(1'b0);
      chk("mid_grant", bus.grant, 32'd0);
      chk("mid_busy", bus.busy, 32'd0);
      chk("mid_en", bus.fifo_dat_en, 32'd0);
      chk("mid_ack", bus.ack, 32'd0);
    end

    // Source 2 single-byte packet, optional header first
    all_log.delete();
    srcq[2].push_back(9'h155);
    drain(100);
`ifdef UART_TX_ARB_HEADER_EN
    chk("h_len", all_log.size(), 2);
    if (all_log.size() == 2) begin
      chk("h_b0", all_log[0], 32'hA2);
      chk("h_b1", all_log[1], 32'h55);
    end
`else
    chk("h_len", all_log.size(), 1);
    if (all_log.size() == 1) chk("h_b0", all_log[0], 32'h55);
`endif

    // Randomized traffic with random FIFO back-pressure
    pay_log.delete();
    n_pushed = 0;
    stall_pct = 25;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 3; i++)
        if ($urandom_range(99) < 12 && srcq[i].size() < 12)
          push_pkt(i, int'($urandom_range(1, 6)), 1'b1);
      step(1'b0);
    end
    drain(3000);
    chk("rnd_total", pay_log.size(), n_pushed);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter MAX_PKT, default 64: the maximum number of payload bytes accepted per grant; legal range 1..127.
REQ-002 SHALL have port clk_100MHz, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port req, input, 3 bits: req[i]=1 means requester i is presenting a valid byte.
REQ-005 SHALL have port dat_in, input, 24 bits: requester i's byte is dat_in[8i+7:8i].
REQ-006 SHALL have port last, input, 3 bits: last[i]=1 marks requester i's current byte as the end of its packet.
REQ-007 SHALL have port ack, output, 3 bits: ack[i]=1 means requester i's byte is consumed this cycle.
REQ-008 SHALL have port grant, output, 3 bits: one-hot registered grant; all zero when no requester owns the FIFO.
REQ-009 SHALL have port fifo_dat, output, 8 bits: registered byte driven to the UART FIFO dat input.
REQ-010 SHALL have port fifo_dat_en, output, 1 bit: registered single-cycle write strobe to the UART FIFO dat_en input.
REQ-011 SHALL have port fifo_afull, input, 1 bit: UART FIFO almost-full flag.
REQ-012 SHALL have port fifo_full, input, 1 bit: UART FIFO full flag.
REQ-013 SHALL have port busy, output, 1 bit: 1 whenever the state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, HDR, SEND and RELEASE; HDR exists only under the configuration macro (REQ-030).
REQ-015 SHALL define stall = fifo_afull | fifo_full.
REQ-016 In IDLE with any req bit set, SHALL select the next requester round-robin, searching from (last_id+1) mod 3, register its grant, clear the byte counter and move to HDR/SEND on the next edge.
REQ-017 In IDLE with req=0, SHALL remain in IDLE with grant=0.
REQ-018 SHALL drive ack[i] combinationally as (state==SEND) & grant[i] & req[i] & ~stall; at most one ack bit may be set in any cycle.
REQ-019 On each ack, SHALL register fifo_dat = granted byte and fifo_dat_en=1 on the next edge, i.e. with 1-cycle latency; otherwise fifo_dat_en=0 and fifo_dat holds its value.
REQ-020 On each ack, SHALL increment the 7-bit byte counter.
REQ-021 SHALL go SEND->RELEASE on an ack with last=1, or on an ack that makes the count equal MAX_PKT; the next byte is then re-arbitrated.
REQ-022 SHALL go SEND->RELEASE if req[grant] is 0 while not stalled (truncated packet); no byte is written in that case.
REQ-023 While stall=1 in SEND or HDR, SHALL hold state, issue no ack and issue no write.
REQ-024 In RELEASE (one cycle), SHALL set last_id to the granted index, clear grant and go to IDLE.
REQ-025 Best-case timing: req rising at IDLE edge n gives grant at n+1, first ack during cycle n+1 (no header) and first fifo_dat_en at n+2.
REQ-026 Simultaneous requests SHALL be served in rotation; a constantly requesting source SHALL wait at most 2 packets.

Reset
REQ-027 On reset=1 at an edge, SHALL set state=IDLE, grant=0, fifo_dat_en=0, fifo_dat=0x00, count=0 and last_id=2, so requester 0 has first priority.
REQ-028 Reset SHALL override every other condition, including reset mid-packet; a packet truncated by reset is not resumed.
REQ-029 ack and busy SHALL be 0 in the cycle after reset.

Configuration
REQ-030 With macro UART_TX_ARB_HEADER_EN defined, SHALL enter HDR after the grant and, when not stalled, write header byte 0xA0|id (0xA0, 0xA1 or 0xA2) with fifo_dat_en, then go to SEND; the header does not count toward MAX_PKT.
REQ-031 With UART_TX_ARB_HEADER_EN undefined, SHALL omit HDR and go IDLE->SEND directly; the byte stream contains payload only.

Verification
REQ-032 After reset, req=001 with 3 bytes 0x11,0x22,0x33 (last on 0x33) SHALL produce 3 fifo_dat_en pulses carrying 0x11,0x22,0x33, then RELEASE and IDLE.
REQ-033 req=111 held, each source sending 1-byte packets, SHALL produce grant order 001,010,100,001.
REQ-034 fifo_afull=1 for 5 cycles mid-packet SHALL produce no ack and no fifo_dat_en for those 5 cycles, with no byte lost or duplicated afterwards.
REQ-035 With MAX_PKT=4 and an unterminated stream from source 1 while source 2 requests, SHALL give source 1 4 bytes, then grant source 2.
REQ-036 reset asserted on the 2nd byte of a packet SHALL give grant=0, busy=0 and fifo_dat_en=0 on the next cycle.
REQ-037 With UART_TX_ARB_HEADER_EN defined and source 2 sending 0x55 (last), SHALL write 0xA2 then 0x55.
